// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Contents: op field width, op code type and the op code constants.
// Op codes 101..111 are not named; they pass the operand through.
package barrel_shifter_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_SLL = 3'b000;  // logical left, zero fill
    localparam op_t OP_SRL = 3'b001;  // logical right, zero fill
    localparam op_t OP_SRA = 3'b010;  // arithmetic right, sign fill
    localparam op_t OP_ROL = 3'b011;  // rotate left
    localparam op_t OP_ROR = 3'b100;  // rotate right

endpackage

// File: rtl/barrel_shift_stage.sv
// One registered stage of the barrel shifter: shifts by SHIFT when sel=1.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   en                      advance enable; all registers hold when low
//   sel                     apply the shift this stage (shift-amount bit k)
//   in_valid/in_data/in_op/in_sign/in_shamt   incoming pipeline slot
//   out_valid/out_data/out_op/out_sign/out_shamt   registered slot
module barrel_shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = 1,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sel,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  op_t              in_op,
    input  logic             in_sign,
    input  logic [SHW-1:0]   in_shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output op_t              out_op,
    output logic             out_sign,
    output logic [SHW-1:0]   out_shamt
);

    logic [WIDTH-1:0] pre;
    logic [WIDTH-1:0] mux_out;

    // Candidate vector already shifted by SHIFT for the current op.
    always_comb begin
        // NOTE: default assigned first so no path leaves 'pre' unassigned,
        // which would otherwise infer a latch.
        pre = in_data;
        case (in_op)
            OP_SLL:  pre = {in_data[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
            OP_SRL:  pre = {{SHIFT{1'b0}}, in_data[WIDTH-1:SHIFT]};
            // Sign comes from the operand MSB captured at accept, not from
            // the partially shifted data.
            OP_SRA:  pre = {{SHIFT{in_sign}}, in_data[WIDTH-1:SHIFT]};
            OP_ROL:  pre = {in_data[WIDTH-1-SHIFT:0], in_data[WIDTH-1:WIDTH-SHIFT]};
            OP_ROR:  pre = {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};
            default: pre = in_data;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux2x1 u_mux (
            .a   (in_data[i]),
            .b   (pre[i]),
            .sel (sel),
            .y   (mux_out[i])
        );
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every stage samples the values
        // its neighbours held before this edge.
        if (!rst_n) begin
            // NOTE: data registers are reset too, not just valid, because
            // the last stage drives out_data, which must read 0 after reset.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_op    <= '0;
            out_sign  <= 1'b0;
            out_shamt <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= mux_out;
            out_op    <= in_op;
            out_sign  <= in_sign;
            out_shamt <= in_shamt;
        end
    end

endmodule

// File: rtl/mux2x1.sv
// Single-bit 2:1 multiplexer primitive.
// Ports: a (selected when sel=0), b (selected when sel=1), sel, y (output).
module mux2x1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready on both sides.
// SHW = log2(WIDTH) registered stages, stage k shifts by 2^k when
// shamt[k]=1, LSB stage first. Latency SHW cycles, one result per clock.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid/in_ready              operand handshake
//   in_data, in_shamt, in_op       operand, shift amount, op code
//   out_valid/out_ready            result handshake
//   out_data, out_op               result and its op code tag
module barrel_shifter_pipe
    import barrel_shifter_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OP_W-1:0]  out_op
);

    // Index 0 is the pipeline input; index k+1 is the register of stage k.
    logic [SHW:0]                 valid_s;
    logic [SHW:0][WIDTH-1:0]      data_s;
    logic [SHW:0][OP_W-1:0]       op_s;
    logic [SHW:0]                 sign_s;
    logic [SHW:0][SHW-1:0]        shamt_s;
    logic                         en;
    logic                         unused_tail;

    // The whole pipeline moves in lock step: it advances whenever the
    // output slot is empty or being drained, bubbles included.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign valid_s[0] = in_valid;
    assign data_s[0]  = in_data;
    assign op_s[0]    = in_op;
    assign sign_s[0]  = in_data[WIDTH-1];
    assign shamt_s[0] = in_shamt;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (2 ** k),
            .SHW   (SHW)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .sel       (shamt_s[k][k]),
            .in_valid  (valid_s[k]),
            .in_data   (data_s[k]),
            .in_op     (op_s[k]),
            .in_sign   (sign_s[k]),
            .in_shamt  (shamt_s[k]),
            .out_valid (valid_s[k+1]),
            .out_data  (data_s[k+1]),
            .out_op    (op_s[k+1]),
            .out_sign  (sign_s[k+1]),
            .out_shamt (shamt_s[k+1])
        );
    end

    assign out_valid = valid_s[SHW];
    assign out_data  = data_s[SHW];
    assign out_op    = op_s[SHW];

    // Sign and shift amount have no consumer past the last stage.
    assign unused_tail = ^{sign_s[SHW], shamt_s[SHW]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [2:0]   in_shamt = '0;
    logic [2:0]   in_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic [2:0]   out_op;

    barrel_shifter_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_op    (out_op)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent reference: rotates via a doubled operand, SRA via signed shift.
    function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input logic [2:0] s,
                                               input logic [2:0] op);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
        dd = {d, d};
        case (op)
            3'd0: r = d << s;
            3'd1: r = d >> s;
            3'd2: r = $unsigned($signed(d) >>> s);
            3'd3: begin dd = dd << s; r = dd[2*W-1:W]; end
            3'd4: begin dd = dd >> s; r = dd[W-1:0]; end
            default: r = d;
        endcase
        return r;
    endfunction

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   op;
    } res_t;

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   shamt;
        logic [2:0]   op;
        logic [W-1:0] expect_data;
    } vec_t;

    // Scoreboard: negedge sampling, handshakes complete at the following posedge.
    res_t         exp_q[$];
    logic [W-1:0] got_q[$];
    bit           sb_on = 1'b0;
    int           n_out = 0;
    int           first_out_cyc = 0;
    int           last_out_cyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (sb_on) begin
            if (out_valid && out_ready) begin
                if (n_out == 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                n_out++;
                got_q.push_back(out_data);
                check("sb_result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sb_data", 32'(out_data), 32'(e.data));
                    check("sb_op", 32'(out_op), 32'(e.op));
                end
            end
            if (in_valid && in_ready) begin
                res_t e;
                e.data = ref_model(in_data, in_shamt, in_op);
                e.op   = in_op;
                exp_q.push_back(e);
            end
        end
    end

    bit rnd_ready = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] d, input logic [2:0] s, input logic [2:0] op);
        bit ok;
        bit done;
        done = 1'b0;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            #0;
            ok = in_ready;
            step();
            if (ok) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) check("send_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            step();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs[14];
    logic [W-1:0] tp_exp[8];

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'hB3, 3'd3, 3'b000, 8'h98};
        vecs[1]  = '{8'hB3, 3'd7, 3'b001, 8'h01};
        vecs[2]  = '{8'hB3, 3'd2, 3'b010, 8'hEC};
        vecs[3]  = '{8'h73, 3'd2, 3'b010, 8'h1C};
        vecs[4]  = '{8'hB3, 3'd1, 3'b100, 8'hD9};
        vecs[5]  = '{8'hB3, 3'd5, 3'b011, 8'h76};
        vecs[6]  = '{8'hB3, 3'd4, 3'b110, 8'hB3};
        vecs[7]  = '{8'hB3, 3'd0, 3'b010, 8'hB3};
        vecs[8]  = '{8'hB3, 3'd0, 3'b011, 8'hB3};
        vecs[9]  = '{8'h5C, 3'd6, 3'b101, 8'h5C};
        vecs[10] = '{8'h80, 3'd7, 3'b010, 8'hFF};
        vecs[11] = '{8'h01, 3'd7, 3'b000, 8'h80};
        vecs[12] = '{8'h01, 3'd7, 3'b100, 8'h02};
        vecs[13] = '{8'hFF, 3'd4, 3'b001, 8'h0F};
        tp_exp = '{8'hB3, 8'h66, 8'hCC, 8'h98, 8'h30, 8'h60, 8'hC0, 8'h80};

        // Reset state; out_ready low so in_ready reflects an empty pipeline.
        out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_op", 32'(out_op), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Directed single operands: result appears in cycle 3 counted from
        // the period right after the accepting edge.
        foreach (vecs[i]) begin
            int lat;
            lat = 0;
            in_data  = vecs[i].data;
            in_shamt = vecs[i].shamt;
            in_op    = vecs[i].op;
            in_valid = 1'b1;
            #0;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                if (out_valid) begin
                    lat = c;
                    break;
                end
                step();
            end
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].expect_data));
            check($sformatf("vec%0d_op", i), 32'(out_op), 32'(vecs[i].op));
            step();
            check($sformatf("vec%0d_no_dup", i), 32'(out_valid), 32'd0);
        end

        sb_on = 1'b1;

        // Throughput: 8 back-to-back SLL operands.
        n_out = 0;
        got_q.delete();
        for (int s = 0; s < 8; s++) send(8'hB3, 3'(s), 3'b000);
        drain();
        check("tp_count", 32'(n_out), 32'd8);
        check("tp_consecutive", 32'(last_out_cyc - first_out_cyc), 32'd7);
        for (int i = 0; i < 8; i++)
            if (i < got_q.size()) check($sformatf("tp_res%0d", i), 32'(got_q[i]), 32'(tp_exp[i]));

        // Stall with full pipeline for 5 cycles.
        n_out = 0;
        out_ready = 1'b0;
        send(8'hC5, 3'd3, 3'b010);
        send(8'h3A, 3'd5, 3'b011);
        send(8'h96, 3'd1, 3'b001);
        in_data  = 8'h71;
        in_shamt = 3'd6;
        in_op    = 3'b100;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", 32'(out_data), 32'(ref_model(8'hC5, 3'd3, 3'b010)));
            step();
        end
        out_ready = 1'b1;
        send(8'h71, 3'd6, 3'b100);
        send(8'h0F, 3'd4, 3'b000);
        send(8'hE1, 3'd2, 3'b111);
        send(8'h42, 3'd7, 3'b011);
        send(8'h99, 3'd0, 3'b001);
        drain();
        check("stall_count", 32'(n_out), 32'd8);

        // Reset with three operands in flight while stalled.
        out_ready = 1'b0;
        send(8'hAA, 3'd1, 3'b000);
        send(8'h55, 3'd2, 3'b001);
        send(8'hF0, 3'd3, 3'b011);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        n_out = 0;
        out_ready = 1'b1;
        repeat (8) step();
        check("midrst_no_stale", 32'(n_out), 32'd0);

        // Random traffic against the reference model.
        rnd_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                send(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end
        rnd_ready = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
